ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single data RAM between two requesters: port I (instruction fetch, word reads only) and port D (load/store unit).
- Sits between the CPU front-end/LSU and the RAM.
- Per-port valid/ready request and response handshakes, round-robin arbitration, and one registered response slot per port.
- Screens misaligned or illegal accesses so they never reach the RAM.

Parameters:
- ADDR_W, 32, address width on requester and RAM ports.
- DATA_W, 32, data width; fixed at 32 and not legal to change.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset; sampled on posedge clk
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted this cycle
- i_addr  in  ADDR_W  fetch byte address
- i_rsp_valid  out  1  fetch response valid
- i_rsp_ready  in  1  fetch response consumed
- i_rsp_data  out  32  fetched word
- i_rsp_err  out  1  fetch misaligned (addr[1:0]!=0)
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1=store, 0=load
- d_access  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, unshifted
- d_rsp_valid  out  1  data response valid
- d_rsp_ready  in  1  data response consumed
- d_rsp_data  out  32  load result (extended); 0 for stores
- d_rsp_err  out  1  misaligned/illegal access
- ram_load  out  1  RAM load enable
- ram_store  out  1  RAM store enable
- ram_access  out  3  RAM access code
- ram_addr  out  32  RAM address
- ram_data_in  out  32  RAM write data
- ram_data_out  in  32  RAM combinational read data

Behaviour:
- Reset (rst=0 at posedge): all rsp_valid=0, rsp_data=0, rsp_err=0, last_grant=D, so I wins the first tie. Reset mid-transaction drops any held response; requesters must reissue.
- Slot state per port:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY when rsp_valid & rsp_ready at posedge.
  - FULL -> FULL when rsp_ready=1 and a new grant occurs in the same cycle. This is back-to-back throughput of 1/cycle/port.
- Eligible(p) = p_req_valid & (slot EMPTY | p_rsp_ready).
- Arbitration (combinational, same cycle):
  - Only one eligible port: grant it.
  - Both eligible: grant the port != last_grant.
  - last_grant updates on every grant.
  - req_ready = granted. At most one of i_req_ready/d_req_ready is high.
- Error check, in the grant cycle:
  - I: err if i_addr[1:0]!=0.
  - D, misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - D, illegal code: 011, 110, 111, or store with 100/101.
  - An errored grant drives ram_load=ram_store=0 but still consumes the grant and produces a response: err=1, data=0.
- RAM drive:
  - Granted legal I: ram_load=1, ram_access=010, ram_addr=i_addr.
  - Granted legal D: ram_load=~we, ram_store=we, ram_access=d_access, ram_addr=d_addr, ram_data_in=d_wdata.
  - Otherwise all RAM outputs 0.
- Latency:
  - Response appears the cycle after the grant.
  - rsp_data latches ram_data_out (loads) or 0 (stores).
  - Stores commit in the RAM at the grant posedge.
- Response holding: rsp_valid, rsp_data and rsp_err are stable while rsp_valid & ~rsp_ready.
- Ordering: a D store granted in cycle N is visible to any load/fetch granted in N+1.
- Combinational paths: no combinational path from rsp_ready to rsp_valid/rsp_data. The req_ready path may depend on rsp_ready.

Test Plan:
- Reset, then fetch at 0x100 with mem[0x40]=0xDEADBEEF: i_req_ready same cycle; i_rsp_valid=1, i_rsp_data=0xDEADBEEF next cycle, err=0.
- Both ports valid every cycle with rsp_ready=1: grants alternate I,D,I,D starting with I; each port sees one response every 2 cycles.
- Store SB 0xAB to 0x203 in cycle N, then LBU 0x203 in N+1: d_rsp_data=0x000000AB; prior LB gives 0xFFFFFFAB.
- d_rsp_ready=0 with slot FULL and d_req_valid=1: d_req_ready=0 and response stays stable for 5 cycles; when rsp_ready=1, the new grant happens the same cycle.
- LW to 0x202 and access=011: ram_load=ram_store=0, d_rsp_err=1, d_rsp_data=0; fetch 0x101: i_rsp_err=1.
- Assert rst=0 while both slots FULL: next cycle both rsp_valid=0, and I wins the first tie after rst=1.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single data RAM.
// Port I (instruction fetch) issues word reads only; port D (load/store unit)
// issues byte/half/word loads and stores. Each port owns one registered
// response slot, arbitration is round-robin, and misaligned or illegal
// requests are answered with an error response without touching the RAM.

module ram_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32   // fixed at 32
) (
    input  logic              clk,
    input  logic              rst,

    // Fetch port
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] i_rsp_data,
    output logic              i_rsp_err,

    // Load/store port
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [2:0]        d_access,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err,

    // RAM side
    output logic              ram_load,
    output logic              ram_store,
    output logic [2:0]        ram_access,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    // Identity of the most recently granted port
    localparam logic GntI = 1'b0;
    localparam logic GntD = 1'b1;

    // Access size codes
    localparam logic [2:0] AccB  = 3'b000;
    localparam logic [2:0] AccH  = 3'b001;
    localparam logic [2:0] AccW  = 3'b010;
    localparam logic [2:0] AccBu = 3'b100;
    localparam logic [2:0] AccHu = 3'b101;

    logic last_grant_q;
    logic last_grant_d;

    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;

    logic i_err;
    logic d_misalign;
    logic d_illegal;
    logic d_err;

    // Eligibility and round-robin grant; a full slot frees up in the same cycle
    // its response is consumed, so rsp_ready feeds req_ready combinationally.
    always_comb begin
        i_elig  = i_req_valid & (~i_rsp_valid | i_rsp_ready);
        d_elig  = d_req_valid & (~d_rsp_valid | d_rsp_ready);
        grant_i = i_elig & (~d_elig | (last_grant_q == GntD));
        grant_d = d_elig & ~grant_i;

        last_grant_d = last_grant_q;
        if (grant_i) begin
            last_grant_d = GntI;
        end else if (grant_d) begin
            last_grant_d = GntD;
        end

        i_req_ready = grant_i;
        d_req_ready = grant_d;
    end

    // Alignment and access-code screening for both ports
    always_comb begin
        i_err = |i_addr[1:0];

        unique case (d_access)
            AccH, AccHu: d_misalign = d_addr[0];
            AccW:        d_misalign = |d_addr[1:0];
            default:     d_misalign = 1'b0;
        endcase

        // Unsigned variants only make sense for loads
        unique case (d_access)
            AccB, AccH, AccW: d_illegal = 1'b0;
            AccBu, AccHu:     d_illegal = d_req_we;
            default:          d_illegal = 1'b1;
        endcase

        d_err = d_misalign | d_illegal;
    end

    // RAM drive: only a legal granted request reaches the RAM
    always_comb begin
        ram_load    = 1'b0;
        ram_store   = 1'b0;
        ram_access  = 3'b000;
        ram_addr    = '0;
        ram_data_in = '0;
        if (grant_i && !i_err) begin
            ram_load   = 1'b1;
            ram_access = AccW;
            ram_addr   = i_addr;
        end else if (grant_d && !d_err) begin
            ram_load    = ~d_req_we;
            ram_store   = d_req_we;
            ram_access  = d_access;
            ram_addr    = d_addr;
            ram_data_in = d_wdata;
        end
    end

    // Round-robin history; reset favours I on the first tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= GntD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Fetch response slot
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= '0;
            i_rsp_err   <= 1'b0;
        end else if (grant_i) begin
            i_rsp_valid <= 1'b1;
            i_rsp_data  <= i_err ? '0 : ram_data_out;
            i_rsp_err   <= i_err;
        end else if (i_rsp_valid && i_rsp_ready) begin
            i_rsp_valid <= 1'b0;
        end
    end

    // Load/store response slot; stores and errors return zero data
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= '0;
            d_rsp_err   <= 1'b0;
        end else if (grant_d) begin
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= (d_err || d_req_we) ? '0 : ram_data_out;
            d_rsp_err   <= d_err;
        end else if (d_rsp_valid && d_rsp_ready) begin
            d_rsp_valid <= 1'b0;
        end
    end

endmodule
